nonce_scanner: RTL
==================

# nonce_scanner

Drives one free-running `sha256_chunk` core to compute Bitcoin double-SHA256 over a range of nonces, given a host-supplied midstate and the 12-byte header tail. It sits directly upstream and downstream of the chunk core: it supplies `data` and `V_in` at every core round-63 boundary, and it samples the core's `hash` output at the same boundary. A nonce counts as found when the final hash word H7 is zero, which is a difficulty-1 share.

## Interface
- No parameters.
- `clk`  in  1  system clock; same clock as the chunk core.
- `rst_n`  in  1  asynchronous, active-low reset.
- `job_start`  in  1  one-cycle pulse; latches the job inputs and begins a scan. A pulse while busy aborts the current scan and restarts.
- `midstate`  in  256  SHA256 state after header bytes 0..63. `midstate[31:0]` = H0 … `[255:224]` = H7.
- `tail`  in  96  header bytes 64..75. `tail[7:0]` = byte 64.
- `nonce_start`, `nonce_end`  in  32 each  inclusive scan range; wraps modulo 2^32.
- `chunk_data`  out  512  to core `data`. `data[7:0]` is the first message byte.
- `chunk_v`  out  256  to core `V_in`.
- `chunk_hash`  in  256  from core `hash`. `[255:224]` = H0 … `[31:0]` = H7.
- `chunk_valid`  in  1  from core `valid`; marks the round-63 cycle.
- `busy`  out  1  high from the cycle after `job_start` until `done`.
- `found`  out  1  one-cycle pulse.
- `found_nonce`  out  32  nonce of the last `found`; holds its value until the next `found`.
- `done`  out  1  one-cycle pulse after the last nonce has been evaluated.

## Operation
- The core latches `chunk_data`/`chunk_v` on the `chunk_valid` cycle. In that same cycle, `chunk_hash` is the result of the chunk latched at the previous `chunk_valid`.
- The core has no reset and its phase is arbitrary, so this block makes every decision on `chunk_valid` only.
- An in-flight tag register records what the core is currently computing: NONE, A(n) or B(n).
- **Pass A:**
  - `chunk_v` = latched midstate.
  - data words 0..2 = tail bytes.
  - word 3 = nonce n, little-endian bytes (`data[103:96]` = n[7:0]).
  - word 4 = 32'h00000080.
  - words 5..14 = 0.
  - word 15 = 32'h80020000 (640-bit length).
- **Pass B:**
  - `chunk_v` = IV (`[31:0]` = 32'h6a09e667 … `[255:224]` = 32'h5be0cd19).
  - data word i = byte-flip of Hi from the current `chunk_hash`. This path is combinational from `chunk_hash` to `chunk_data`.
  - word 8 = 32'h00000080.
  - words 9..14 = 0.
  - word 15 = 32'h00010000 (256-bit length).
- **States:**
  - IDLE: drives the all-zero chunk with tag NONE; results are ignored. `job_start` latches the job, sets n = `nonce_start`, sets `last` = (n == `nonce_end`), and moves to RUN.
  - RUN, on each `chunk_valid`:
    - Tag NONE or B(n): if the tag is B(n), evaluate its result first. Then, if more nonces remain, load A(next n). If none remain, load zero, pulse `done`, and go to IDLE.
    - Tag A(n): load B(n) from `chunk_hash` and set the tag to B(n).
- **Evaluation:**
  - `chunk_hash[31:0]` == 0 → `found`=1, `found_nonce`=n.
  - When `last` is set, `done` pulses in the same cycle as any `found` for that nonce.
- **Nonce advance:** n+1 modulo 2^32. `last` = (n+1 == `nonce_end`). Thus start==end scans one nonce, and start=0/end=FFFFFFFF scans all 2^32.
- **`job_start` while busy:**
  - Tag forced to NONE, so the in-flight result is discarded.
  - No `done` is produced for the aborted job.
  - The new job starts at the next `chunk_valid`.
- **`job_start` coinciding with `chunk_valid`:** the new job takes priority. Its A pass loads at the next `chunk_valid`, not in this one.
- **Reset (asynchronous, any time):** state IDLE, tag NONE, and `busy`, `found`, `done`, `found_nonce` all 0.

## Timing
- Each nonce costs 128 cycles (two core passes).
- First A load occurs 1..64 cycles after `job_start`.
- `found` and `done` are registered: they assert 1 cycle after the `chunk_valid` carrying the B result.
- First-nonce `found` therefore asserts 130..193 cycles after `job_start`.
- `chunk_data`/`chunk_v` must be stable during each `chunk_valid` cycle. Outside those cycles their values are don't-care.

## Structure
- `miner_pkg`:
  - IV words.
  - Padding and length words for both passes.
  - State and tag enums.
  - a `flipbytes` function.
- One sub-module, `nonce_chunk_mux`: combinational formatting of pass-A/pass-B `data` and `V` from tag, job registers and `chunk_hash`.

## Test plan
All scenarios run against a real `sha256_chunk` instance; the genesis-header midstate and tail come from the host model.
- Genesis job, range 0x7C2BAC1A..0x7C2BAC20 → exactly one `found` with `found_nonce`=0x7C2BAC1D. `done` follows after 7 nonces (≈896 cycles); `busy` is low afterwards.
- start=end=0x7C2BAC1D → `found` and `done` in the same cycle, 130..193 cycles after `job_start`.
- Range 0xFFFFFFFF..0x00000001 → A passes observed with nonces FFFFFFFF, 0, 1, then `done`.
- Golden check: the pass-B `chunk_data` for nonce 0 matches the byte-flipped model SHA256 of pass A, and the B hash matches the model SHA256d.
- `job_start` issued mid-B pass of nonce 0x7C2BAC1D, with new range 0..3 → no `found` for the old job, no `done` for the old job, and new A loads begin with nonce 0.
- `rst_n` pulsed low mid-scan → all outputs 0 immediately. A subsequent job then scans correctly regardless of the core's phase.

Source files
------------

// File: rtl/miner_pkg.sv
// miner_pkg: shared constants and helpers for the nonce scanner.
//   IV_WORDS    - SHA256 initial state, H0 in [31:0] ... H7 in [255:224]
//   PAD_WORD    - first padding byte 0x80 packed as a little-endian data word
//   LEN_A_WORD  - 640-bit message length word (pass A, header second chunk)
//   LEN_B_WORD  - 256-bit message length word (pass B, digest-of-digest)
//   state_e     - scanner control states
//   tag_e       - what the chunk core is currently working on
//   flipbytes() - reverse the byte order of a 32-bit word
package miner_pkg;

  localparam logic [255:0] IV_WORDS = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] PAD_WORD   = 32'h00000080;
  localparam logic [31:0] LEN_A_WORD = 32'h80020000;
  localparam logic [31:0] LEN_B_WORD = 32'h00010000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_A    = 2'd1,
    TAG_B    = 2'd2
  } tag_e;

  // Digest words are big-endian, message words are little-endian.
  function automatic logic [31:0] flipbytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/nonce_chunk_mux.sv
// nonce_chunk_mux: formats the 512-bit message chunk and 256-bit chaining
// value handed to the sha256_chunk core.
//   load_sel_i  - TAG_A: header tail + nonce under the midstate
//                 TAG_B: byte-flipped pass-A digest under the IV
//                 TAG_NONE: all-zero chunk and chaining value
//   midstate_i  - latched job midstate
//   tail_i      - latched header bytes 64..75
//   nonce_i     - nonce for a pass-A chunk
//   hash_i      - current core digest, H0 in [255:224]
//   data_o      - chunk to core, first message byte in [7:0]
//   v_o         - chaining value to core
module nonce_chunk_mux
  import miner_pkg::*;
(
  input  tag_e           load_sel_i,
  input  logic [255:0]   midstate_i,
  input  logic [95:0]    tail_i,
  input  logic [31:0]    nonce_i,
  input  logic [255:0]   hash_i,
  output logic [511:0]   data_o,
  output logic [255:0]   v_o
);

  // Chunk formatting; the pass-B path is purely combinational from hash_i.
  always_comb begin
    data_o = '0;
    v_o    = '0;
    case (load_sel_i)
      TAG_A: begin
        data_o[95:0]    = tail_i;
        data_o[127:96]  = nonce_i;
        data_o[159:128] = PAD_WORD;
        data_o[511:480] = LEN_A_WORD;
        v_o             = midstate_i;
      end
      TAG_B: begin
        for (int i = 0; i < 8; i++) begin
          data_o[32*i +: 32] = flipbytes(hash_i[255-32*i -: 32]);
        end
        data_o[287:256] = PAD_WORD;
        data_o[511:480] = LEN_B_WORD;
        v_o             = IV_WORDS;
      end
      default: begin
        data_o = '0;
        v_o    = '0;
      end
    endcase
  end

endmodule

// File: rtl/nonce_scanner.sv
// nonce_scanner: drives a free-running sha256_chunk core through Bitcoin
// double-SHA256 over an inclusive, wrapping nonce range and reports nonces
// whose final digest word H7 is zero.
//   clk, rst_n         - clock shared with the core, async active-low reset
//   job_start          - pulse: latch job and (re)start a scan
//   midstate, tail     - header midstate and header bytes 64..75
//   nonce_start/_end   - inclusive nonce range
//   chunk_data/chunk_v - chunk and chaining value to the core
//   chunk_hash         - core digest, H0 in [255:224] ... H7 in [31:0]
//   chunk_valid        - core round-63 marker; the only decision point
//   busy, found, found_nonce, done - status outputs
module nonce_scanner
  import miner_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           job_start,
  input  logic [255:0]   midstate,
  input  logic [95:0]    tail,
  input  logic [31:0]    nonce_start,
  input  logic [31:0]    nonce_end,
  output logic [511:0]   chunk_data,
  output logic [255:0]   chunk_v,
  input  logic [255:0]   chunk_hash,
  input  logic           chunk_valid,
  output logic           busy,
  output logic           found,
  output logic [31:0]    found_nonce,
  output logic           done
);

  state_e        state_q, state_d;
  tag_e          tag_q, tag_d;
  tag_e          load_sel;
  logic [255:0]  mid_q, mid_d;
  logic [95:0]   tail_q, tail_d;
  logic [31:0]   end_q, end_d;
  logic [31:0]   next_q, next_d;   // next nonce to start as pass A
  logic [31:0]   cur_q, cur_d;     // nonce currently in flight
  logic          more_q, more_d;   // next_q has not been started yet
  logic          busy_q, busy_d;
  logic          found_q, found_d;
  logic [31:0]   fnonce_q, fnonce_d;
  logic          done_q, done_d;

  // Chunk the core would latch if this cycle is a chunk_valid cycle.
  // A job_start always wins, so its first A pass waits for the next boundary.
  always_comb begin
    load_sel = TAG_NONE;
    if (job_start) begin
      load_sel = TAG_NONE;
    end else if (state_q == ST_RUN) begin
      if (tag_q == TAG_A) begin
        load_sel = TAG_B;
      end else if (more_q) begin
        load_sel = TAG_A;
      end else begin
        load_sel = TAG_NONE;
      end
    end else begin
      load_sel = TAG_NONE;
    end
  end

  nonce_chunk_mux u_mux (
    .load_sel_i (load_sel),
    .midstate_i (mid_q),
    .tail_i     (tail_q),
    .nonce_i    (next_q),
    .hash_i     (chunk_hash),
    .data_o     (chunk_data),
    .v_o        (chunk_v)
  );

  // Scan control: job latch, pass sequencing and result evaluation.
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    mid_d    = mid_q;
    tail_d   = tail_q;
    end_d    = end_q;
    next_d   = next_q;
    cur_d    = cur_q;
    more_d   = more_q;
    found_d  = 1'b0;
    fnonce_d = fnonce_q;
    done_d   = 1'b0;
    if (job_start) begin
      // Also the abort path: forcing NONE drops any in-flight result.
      mid_d   = midstate;
      tail_d  = tail;
      end_d   = nonce_end;
      next_d  = nonce_start;
      more_d  = 1'b1;
      tag_d   = TAG_NONE;
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && chunk_valid) begin
      case (tag_q)
        TAG_A: begin
          tag_d = TAG_B;
        end
        TAG_NONE, TAG_B: begin
          if ((tag_q == TAG_B) && (chunk_hash[31:0] == 32'd0)) begin
            found_d  = 1'b1;
            fnonce_d = cur_q;
          end else begin
            found_d  = 1'b0;
          end
          if (more_q) begin
            tag_d  = TAG_A;
            cur_d  = next_q;
            next_d = next_q + 32'd1;
            // The nonce being started is the last one when it equals end.
            more_d = (next_q != end_q);
          end else begin
            tag_d   = TAG_NONE;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          tag_d = TAG_NONE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tag_q    <= TAG_NONE;
      mid_q    <= '0;
      tail_q   <= '0;
      end_q    <= 32'd0;
      next_q   <= 32'd0;
      cur_q    <= 32'd0;
      more_q   <= 1'b0;
      busy_q   <= 1'b0;
      found_q  <= 1'b0;
      fnonce_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      mid_q    <= mid_d;
      tail_q   <= tail_d;
      end_q    <= end_d;
      next_q   <= next_d;
      cur_q    <= cur_d;
      more_q   <= more_d;
      busy_q   <= busy_d;
      found_q  <= found_d;
      fnonce_q <= fnonce_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign found       = found_q;
  assign found_nonce = fnonce_q;
  assign done        = done_q;

endmodule
